// File: rtl/wupr_pkg.sv
// Shared definitions for the WUPR row tracker and its refresh-side initiator.
//   ROW_WIDTH_DEFAULT : default row address width (WUPR Ra width)
//   row_t             : row address at the default width
//   state_t           : refresh issuer walk states
package wupr_pkg;

  localparam int unsigned ROW_WIDTH_DEFAULT = 16;

  typedef logic [ROW_WIDTH_DEFAULT-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    QUERY = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    NEXT  = 3'd4
  } state_t;

endpackage

// File: rtl/wupr_refi_timer.sv
// Refresh interval timer with one-deep tick queue.
//   clk, rst_n  : clock, asynchronous active-low reset
//   refresh_en  : counts while high, holds value while low
//   busy        : walk FSM is outside IDLE
//   tick        : one-cycle pulse on the last cycle of each interval
//   pending     : one interval is queued behind the running walk
//   overrun     : sticky, a tick arrived with the queue already full
module wupr_refi_timer #(
  parameter int unsigned TREFI_CYCLES = 3900
) (
  input  logic clk,
  input  logic rst_n,
  input  logic refresh_en,
  input  logic busy,
  output logic tick,
  output logic pending,
  output logic overrun
);

  localparam int unsigned TW = (TREFI_CYCLES > 1) ? $clog2(TREFI_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TREFI_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;

  always_comb begin
    tick      = refresh_en && (timer_q == LAST);
    timer_d   = timer_q;
    pending_d = pending_q;
    overrun_d = overrun_q;

    if (refresh_en) begin
      timer_d = tick ? '0 : timer_q + 1'b1;
    end

    // An idle FSM launches from pending in this same cycle.
    if (!busy && pending_q) begin
      pending_d = 1'b0;
    end

    if (tick) begin
      if (busy) begin
        if (pending_q) begin
          overrun_d = 1'b1;
        end else begin
          pending_d = 1'b1;
        end
      end else if (pending_q) begin
        // Pending launches the walk now; this tick queues the next one.
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/wupr_refresh_issuer.sv
// Refresh-side initiator for the WUPR row tracker. Each refresh interval it
// walks ROWS_PER_TICK rows, queries WUPR per row, and either issues a
// refresh request to the scheduler (dref=1) or skips the row (dref=0).
//   clk, rst_n       : clock, asynchronous active-low reset
//   refresh_en       : enables the interval timer
//   clk_enable       : WUPR ready; gates query launch only
//   to_refresh, Ra   : one-cycle query strobe and row address
//   dref             : WUPR verdict, sampled DREF_LAT cycles after the strobe
//   ref_req/ref_row  : refresh request to the scheduler, held until ref_ack
//   ref_ack          : scheduler accept
//   busy             : FSM outside IDLE
//   overrun          : sticky lost-interval flag
//   skip_cnt/issue_cnt : saturating statistics
module wupr_refresh_issuer
  import wupr_pkg::*;
#(
  parameter int unsigned ROW_WIDTH     = ROW_WIDTH_DEFAULT,
  parameter int unsigned ROWS_PER_TICK = 8,
  parameter int unsigned TREFI_CYCLES  = 3900,
  parameter int unsigned DREF_LAT      = 1,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 refresh_en,
  input  logic                 clk_enable,
  output logic                 to_refresh,
  output logic [ROW_WIDTH-1:0] Ra,
  input  logic                 dref,
  output logic                 ref_req,
  output logic [ROW_WIDTH-1:0] ref_row,
  input  logic                 ref_ack,
  output logic                 busy,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] skip_cnt,
  output logic [CNT_WIDTH-1:0] issue_cnt
);

  localparam int unsigned BW = $clog2(ROWS_PER_TICK + 1);
  localparam int unsigned LW = (DREF_LAT > 1) ? $clog2(DREF_LAT) : 1;

  state_t               state_q, state_d;
  logic [ROW_WIDTH-1:0] row_ptr_q, row_ptr_d;
  logic [ROW_WIDTH-1:0] ref_row_q, ref_row_d;
  logic [BW-1:0]        batch_q, batch_d;
  logic [LW-1:0]        lat_q, lat_d;
  logic [CNT_WIDTH-1:0] skip_q, skip_d;
  logic [CNT_WIDTH-1:0] issue_q, issue_d;

  logic tick;
  logic pending;

  wupr_refi_timer #(
    .TREFI_CYCLES (TREFI_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .refresh_en (refresh_en),
    .busy       (busy),
    .tick       (tick),
    .pending    (pending),
    .overrun    (overrun)
  );

  always_comb begin
    state_d   = state_q;
    row_ptr_d = row_ptr_q;
    ref_row_d = ref_row_q;
    batch_d   = batch_q;
    lat_d     = lat_q;
    skip_d    = skip_q;
    issue_d   = issue_q;

    case (state_q)
      IDLE: begin
        if (tick || pending) begin
          state_d = QUERY;
          batch_d = BW'(ROWS_PER_TICK);
        end
      end
      QUERY: begin
        if (clk_enable) begin
          state_d = WAIT;
          lat_d   = LW'(DREF_LAT - 1);
        end
      end
      WAIT: begin
        // lat_q counts down; dref is only looked at when it reaches zero.
        if (lat_q == '0) begin
          if (dref) begin
            ref_row_d = row_ptr_q;
            state_d   = ISSUE;
          end else begin
            if (skip_q != '1) begin
              skip_d = skip_q + 1'b1;
            end
            state_d = NEXT;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ISSUE: begin
        if (ref_ack) begin
          if (issue_q != '1) begin
            issue_d = issue_q + 1'b1;
          end
          state_d = NEXT;
        end
      end
      NEXT: begin
        row_ptr_d = row_ptr_q + 1'b1;
        batch_d   = batch_q - 1'b1;
        state_d   = (batch_q == BW'(1)) ? IDLE : QUERY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_ptr_q <= '0;
      ref_row_q <= '0;
      batch_q   <= '0;
      lat_q     <= '0;
      skip_q    <= '0;
      issue_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_ptr_q <= row_ptr_d;
      ref_row_q <= ref_row_d;
      batch_q   <= batch_d;
      lat_q     <= lat_d;
      skip_q    <= skip_d;
      issue_q   <= issue_d;
    end
  end

  // The strobe follows clk_enable combinationally so the launch cycle is
  // the first cycle WUPR is ready.
  assign to_refresh = (state_q == QUERY) && clk_enable;
  assign Ra         = row_ptr_q;
  assign ref_req    = (state_q == ISSUE);
  assign ref_row    = ref_row_q;
  assign busy       = (state_q != IDLE);
  assign skip_cnt   = skip_q;
  assign issue_cnt  = issue_q;

endmodule

// File: tb/tb_wupr_refresh_issuer.sv
// Scoreboard bench for wupr_refresh_issuer. The monitor process plays the
// WUPR and scheduler roles, queues the expected row sequence and refresh
// requests, and compares whenever the DUT strobes a query or raises ref_req.
module tb_wupr_refresh_issuer;

  localparam int ROW_W = 4;
  localparam int ROWS  = 4;
  localparam int TREFI = 64;
  localparam int LAT   = 2;
  localparam int CW    = 5;
  localparam int CMAX  = (1 << CW) - 1;

  logic             clk;
  logic             rst_n;
  logic             refresh_en;
  logic             clk_enable;
  logic             to_refresh;
  logic [ROW_W-1:0] Ra;
  logic             dref;
  logic             ref_req;
  logic [ROW_W-1:0] ref_row;
  logic             ref_ack;
  logic             busy;
  logic             overrun;
  logic [CW-1:0]    skip_cnt;
  logic [CW-1:0]    issue_cnt;

  wupr_refresh_issuer #(
    .ROW_WIDTH     (ROW_W),
    .ROWS_PER_TICK (ROWS),
    .TREFI_CYCLES  (TREFI),
    .DREF_LAT      (LAT),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .refresh_en (refresh_en),
    .clk_enable (clk_enable),
    .to_refresh (to_refresh),
    .Ra         (Ra),
    .dref       (dref),
    .ref_req    (ref_req),
    .ref_row    (ref_row),
    .ref_ack    (ref_ack),
    .busy       (busy),
    .overrun    (overrun),
    .skip_cnt   (skip_cnt),
    .issue_cnt  (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int cyc = 0;
  int tmr = 0;
  int tick_total = 0;
  int q_total = 0;
  int exp_ra = 0;
  int exp_skip = 0;
  int exp_issue = 0;
  int sched_cyc[$];
  bit sched_v[$];
  int ref_q[$];
  int hold = 0;
  int ack_delay_cur = 1;
  bit after_ack = 0;
  bit expect_start = 0;

  // Stimulus knobs: dref_mode 0=never,1=always,2=random,3=odd rows
  int dref_mode = 0;
  bit ack_hold  = 0;
  int ack_fixed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  initial begin : monitor
    bit v;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        exp_ra = 0; exp_skip = 0; exp_issue = 0; tmr = 0;
        hold = 0; after_ack = 0; expect_start = 0;
        sched_cyc.delete(); sched_v.delete(); ref_q.delete();
        dref = 1'b0; ref_ack = 1'b0;
      end else begin
        // WUPR side: verdict only in the sample cycle, noise elsewhere
        if (sched_cyc.size() != 0 && sched_cyc[0] == cyc) begin
          dref = sched_v[0];
          void'(sched_cyc.pop_front());
          void'(sched_v.pop_front());
        end else begin
          dref = 1'($urandom_range(0, 1));
        end

        if (expect_start && clk_enable) begin
          chk("start_latency", to_refresh, 1);
          expect_start = 0;
        end

        if (to_refresh) begin
          chk("launch_while_gated", clk_enable, 1);
          chk("Ra_sequence", Ra, exp_ra);
          case (dref_mode)
            0: v = 1'b0;
            1: v = 1'b1;
            3: v = exp_ra[0];
            default: v = 1'($urandom_range(0, 1));
          endcase
          sched_cyc.push_back(cyc + LAT);
          sched_v.push_back(v);
          if (v) ref_q.push_back(exp_ra);
          else   exp_skip++;
          exp_ra = (exp_ra + 1) % (1 << ROW_W);
          q_total++;
        end

        if (after_ack) begin
          chk("req_after_ack", ref_req, 0);
          after_ack = 0;
        end

        // Scheduler side
        if (ref_req) begin
          if (ref_q.size() == 0) begin
            chk("unexpected_req", ref_req, 0);
            ref_ack = 1'b1;
            hold = 0;
          end else begin
            if (hold == 0) ack_delay_cur = (ack_fixed != 0) ? ack_fixed : $urandom_range(1, 4);
            hold++;
            chk("ref_row", ref_row, ref_q[0]);
            ref_ack = !ack_hold && (hold >= ack_delay_cur);
            if (ref_ack) begin
              void'(ref_q.pop_front());
              exp_issue++;
              hold = 0;
              after_ack = 1;
            end
          end
        end else begin
          if (hold != 0) chk("req_dropped_early", ref_req, 1);
          hold = 0;
          ref_ack = 1'($urandom_range(0, 1));
        end

        // Interval timer model
        if (refresh_en && tmr == TREFI - 1) begin
          tick_total++;
          if (!busy) expect_start = 1;
        end
        if (refresh_en) tmr = (tmr == TREFI - 1) ? 0 : tmr + 1;
      end
    end
  end

  task automatic wait_ticks(input int k);
    int target;
    int i;
    target = tick_total + k;
    i = 0;
    while (tick_total < target && i < k * TREFI + 20) begin
      @(negedge clk);
      i++;
    end
    if (tick_total < target) chk("tick_timeout", tick_total, target);
  endtask

  task automatic wait_idle();
    int run;
    int i;
    run = 0;
    i = 0;
    while (run < 3 && i < 600) begin
      @(negedge clk);
      run = busy ? 0 : run + 1;
      i++;
    end
    if (run < 3) chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_req();
    int i;
    i = 0;
    while (!ref_req && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (!ref_req) chk("req_timeout", ref_req, 1);
  endtask

  // Returns at the negedge of a cycle in which the interval tick fires.
  task automatic wait_tick_cycle();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (tmr != TREFI - 1 && i < 200);
    if (tmr != TREFI - 1) chk("tick_sync_timeout", tmr, TREFI - 1);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_skip_cnt"}, skip_cnt, sat(exp_skip));
    chk({tag, "_issue_cnt"}, issue_cnt, sat(exp_issue));
    chk({tag, "_req_queue_empty"}, ref_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_to_refresh"}, to_refresh, 0);
    chk({tag, "_Ra"}, Ra, 0);
    chk({tag, "_ref_req"}, ref_req, 0);
    chk({tag, "_ref_row"}, ref_row, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_skip_cnt"}, skip_cnt, 0);
    chk({tag, "_issue_cnt"}, issue_cnt, 0);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int q0;
    rst_n = 1'b0; refresh_en = 1'b0; clk_enable = 1'b0;
    dref = 1'b0; ref_ack = 1'b0;
    repeat (3) @(negedge clk);
    clk_enable = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1; refresh_en = 1'b1;

    // All rows skipped
    dref_mode = 0;
    wait_ticks(1);
    wait_idle();
    check_counts("skip_only");
    chk("skip_only_abs", skip_cnt, 4);

    // Odd rows refreshed, ack in third request cycle
    dref_mode = 3; ack_fixed = 3;
    wait_ticks(1);
    wait_idle();
    check_counts("odd_rows");
    chk("odd_rows_issue_abs", issue_cnt, 2);

    // clk_enable low for 10 cycles at the first query of a batch
    dref_mode = 0; ack_fixed = 0;
    wait_tick_cycle();
    clk_enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("gated_busy", busy, 1);
    chk("gated_no_strobe", to_refresh, 0);
    repeat (6) @(negedge clk);
    clk_enable = 1'b1;
    wait_idle();
    check_counts("gated");

    // refresh_en dropped mid-walk: batch completes, no further walks
    dref_mode = 2;
    wait_tick_cycle();
    q0 = q_total;
    repeat (3) @(negedge clk);
    refresh_en = 1'b0;
    repeat (300) @(negedge clk);
    chk("en_drop_batch_rows", q_total - q0, ROWS);
    chk("en_drop_idle", busy, 0);
    refresh_en = 1'b1;

    // Random traffic with gated launches; counters run into saturation
    for (int i = 0; i < 30 * TREFI; i++) begin
      @(negedge clk);
      clk_enable = ($urandom_range(0, 3) != 0);
    end
    clk_enable = 1'b1;
    refresh_en = 1'b0;
    wait_idle();
    check_counts("random_sat");
    chk("overrun_clear", overrun, 0);

    // Stalled ack: second tick queues, third tick overruns
    refresh_en = 1'b1; dref_mode = 1; ack_hold = 1;
    wait_req();
    q0 = tick_total;
    wait_ticks(1);
    repeat (2) @(negedge clk);
    chk("pending_no_overrun", overrun, 0);
    wait_ticks(1);
    repeat (2) @(negedge clk);
    chk("overrun_set", overrun, 1);
    chk("overrun_tick_count", tick_total - q0, 2);
    ack_hold = 0;
    begin
      int i;
      i = 0;
      while (busy && i < 300) begin
        @(negedge clk);
        i++;
      end
    end
    chk("stall_batch_done", busy, 0);
    @(negedge clk);
    chk("pending_back_to_back", busy, 1);
    wait_idle();
    chk("overrun_sticky", overrun, 1);

    // Reset in the middle of a held refresh request
    ack_hold = 1; dref_mode = 1;
    wait_req();
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    ack_hold = 0; dref_mode = 2;
    rst_n = 1'b1;
    wait_ticks(3);
    refresh_en = 1'b0;
    wait_idle();
    check_counts("post_reset");
    chk("post_reset_rows", skip_cnt + issue_cnt, 3 * ROWS);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/wupr_refresh_issuer.md
Name: wupr_refresh_issuer

Overview:
Refresh-side initiator for the WUPR row tracker. On every refresh interval it walks a batch of row addresses and queries WUPR per row with to_refresh/Ra. It samples the dref verdict, then either issues a per-row refresh request to the command scheduler or skips the row. It maintains the global row pointer, interval timing, pending-interval bookkeeping and skip/issue statistics.

Parameters:
ROW_WIDTH, 16, row address width; matches WUPR Ra width
ROWS_PER_TICK, 8, rows walked per refresh interval (>=1)
TREFI_CYCLES, 3900, clock cycles per refresh interval (>=ROWS_PER_TICK*4)
DREF_LAT, 1, cycles from to_refresh pulse to valid dref (1..4)
CNT_WIDTH, 16, width of statistics counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
refresh_en  in  1  enables interval timer and walking; low freezes the timer
clk_enable  in  1  WUPR ready/clock-enabled; a query launches only while high
to_refresh  out  1  one-cycle query strobe to WUPR
Ra  out  ROW_WIDTH  row being queried; valid while to_refresh=1
dref  in  1  WUPR verdict (1=refresh needed), sampled DREF_LAT cycles after to_refresh
ref_req  out  1  refresh command request to scheduler; held until ref_ack
ref_row  out  ROW_WIDTH  row to refresh; stable while ref_req=1
ref_ack  in  1  scheduler accepts request in the cycle ref_req&&ref_ack
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky: an interval tick was lost
skip_cnt  out  CNT_WIDTH  rows skipped (dref=0), saturating
issue_cnt  out  CNT_WIDTH  rows refreshed (ack'd), saturating

Behaviour:
- Reset (async, rst_n=0): all outputs 0, Ra=0, ref_row=0, row pointer=0, timer=0, pending=0, state=IDLE. Mid-operation reset abandons any outstanding query or ref_req; no ack is expected afterwards.
- Timer: increments while refresh_en=1. At TREFI_CYCLES-1 it wraps to 0 and raises a one-cycle tick. refresh_en=0 holds the timer value; pending is kept.
- Pending: 1-bit. A tick in IDLE starts a walk directly. A tick while busy sets pending=1. A tick while busy with pending already 1 sets overrun=1 (sticky until reset) and the tick is dropped.
- FSM:
  - IDLE -> QUERY on tick, or on pending=1 (pending then clears). Batch counter loads ROWS_PER_TICK.
  - QUERY: waits for clk_enable=1, then drives to_refresh=1 and Ra=row pointer for exactly one cycle -> WAIT.
  - WAIT: counts DREF_LAT cycles and samples dref in the final one.
    - dref=1 -> ISSUE, with ref_row=Ra.
    - dref=0 -> skip_cnt+1 -> NEXT.
  - ISSUE: ref_req=1 until ref_ack. In the ack cycle: ref_req drops next cycle, issue_cnt+1 -> NEXT. An ack in the first cycle gives a 1-cycle handshake.
  - NEXT: row pointer+1, wrapping at 2^ROW_WIDTH-1 -> 0. Batch counter -1. Zero -> IDLE, else -> QUERY.
- Minimum per-row latency: QUERY 1 + WAIT DREF_LAT + NEXT 1 (skip path), +1 or more for ISSUE.
- clk_enable low during WAIT/ISSUE has no effect; it gates query launch only.
- refresh_en dropping mid-walk: the current batch completes; no new tick is generated.
- Counters saturate at all-ones and never wrap.
- dref is ignored outside the sample cycle. ref_ack is ignored when ref_req=0.

Decomposition:
- Package wupr_pkg: typedef row_t (logic [ROW_WIDTH-1:0]), state enum {IDLE, QUERY, WAIT, ISSUE, NEXT}, shared ROW_WIDTH default. WUPR and this block both import it.
- One sub-module: wupr_refi_timer (interval counter, tick, pending/overrun logic). The FSM, row pointer and stats stay in the top.

Test Plan:
- TREFI=64, ROWS_PER_TICK=4, dref always 0, clk_enable=1 -> per tick four to_refresh pulses with Ra=0,1,2,3; skip_cnt=4, ref_req never asserted.
- dref=1 for rows 1,3, ref_ack after 3 cycles -> ref_req rows 1,3 each held exactly 3 cycles; issue_cnt=2, skip_cnt=2.
- Row pointer preset to 0xFFFE via walks, ROWS_PER_TICK=4 -> Ra sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- clk_enable low 10 cycles at a query -> to_refresh deferred until clk_enable=1; Ra unchanged; no dref sampled early.
- ref_ack held 0 for 3*TREFI -> second tick sets pending, third sets overrun=1; after ack, a back-to-back batch starts from pending.
- Reset asserted during ISSUE with ref_req=1 -> all outputs 0 immediately; after release the first query uses Ra=0.
